// File: rtl/gate_selftest_ctrl.sv
// Purpose : built-in self-test sequencer for the two-input basic gate block.
// Latency : start edge to done pulse is 4*SETTLE_CYCLES+5 cycles.
// Backpr. : none; start is only honoured in IDLE and is never queued.
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   start          request a run (accepted only while idle)
//   o_a, o_b       operands driven to the gate block, {o_a,o_b} == vec_idx
//   i_gates        gate block outputs {and, or, nand, nor, xor, xnor}
//   busy           high whenever a run is in progress (including DONE)
//   done           one-cycle pulse marking the end of a run
//   pass           last completed run had no mismatches; held until next start
//   fail_vec       per-vector mismatch flags, bit k for {a,b} == k
//   err_gate       OR of mismatching gate bits over all vectors
//   vec_idx        index of the vector currently applied
module gate_selftest_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter bit          LOOP          = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       o_a,
  output logic       o_b,
  input  logic [5:0] i_gates,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec,
  output logic [5:0] err_gate,
  output logic [1:0] vec_idx
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // The counter counts down from SETTLE_CYCLES-1 to 0, giving exactly
  // SETTLE_CYCLES cycles of settle time per vector.
  localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [7:0] settle_cnt;
  logic [5:0] sample;
  logic [5:0] expected;
  logic [5:0] mismatch;
  logic [3:0] fail_vec_nxt;
  logic [5:0] err_gate_nxt;
  logic [1:0] vec_idx_inc;

  // Ideal truth table for the operands currently applied.
  always_comb begin
    expected = {o_a & o_b, o_a | o_b, ~(o_a & o_b), ~(o_a | o_b),
                o_a ^ o_b, ~(o_a ^ o_b)};
  end

  // Each bit defaults to "mismatch" and is cleared only on a clean equality,
  // so an X or Z sample bit (whose compare is unknown) reports as a mismatch.
  always_comb begin
    mismatch = 6'b111111;
    for (int i = 0; i < 6; i++) begin
      if (sample[i] == expected[i]) begin
        mismatch[i] = 1'b0;
      end else begin
        mismatch[i] = 1'b1;
      end
    end
  end

  // Result accumulators as they will look after the current CHECK cycle;
  // pass in DONE is derived from these so the last vector is included.
  always_comb begin
    fail_vec_nxt = fail_vec;
    if (|mismatch) begin
      fail_vec_nxt[vec_idx] = 1'b1;
    end
    err_gate_nxt = err_gate | mismatch;
    vec_idx_inc  = vec_idx + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= 8'd0;
      sample     <= 6'd0;
      o_a        <= 1'b0;
      o_b        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_vec   <= 4'd0;
      err_gate   <= 6'd0;
      vec_idx    <= 2'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= SETTLE;
            busy       <= 1'b1;
            vec_idx    <= 2'd0;
            {o_a, o_b} <= 2'b00;
            fail_vec   <= 4'd0;
            err_gate   <= 6'd0;
            pass       <= 1'b0;
            settle_cnt <= CNT_LOAD;
          end
        end

        SETTLE: begin
          if (settle_cnt == 8'd0) begin
            sample <= i_gates;
            state  <= CHECK;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end

        CHECK: begin
          fail_vec <= fail_vec_nxt;
          err_gate <= err_gate_nxt;
          if (vec_idx == 2'd3) begin
            state <= DONE;
            done  <= 1'b1;
            pass  <= (fail_vec_nxt == 4'd0);
          end else begin
            vec_idx    <= vec_idx_inc;
            {o_a, o_b} <= vec_idx_inc;
            settle_cnt <= CNT_LOAD;
            state      <= SETTLE;
          end
        end

        DONE: begin
          vec_idx    <= 2'd0;
          {o_a, o_b} <= 2'b00;
          if (LOOP) begin
            // Free-running mode: clear the per-run results but keep pass
            // from the run just finished until the next DONE updates it.
            state      <= SETTLE;
            fail_vec   <= 4'd0;
            err_gate   <= 6'd0;
            settle_cnt <= CNT_LOAD;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_selftest_ctrl.sv
// Testbench for gate_selftest_ctrl: one instance with S=4 run-once, one with
// S=1 free-running. A behavioural gate block with per-vector fault masks feeds
// each instance; expected results are derived from the fault masks.
module tb_gate_selftest_ctrl;

  localparam int S0 = 4;
  localparam int S1 = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance 0 (S=4, LOOP=0)
  logic       start0;
  logic       o_a0, o_b0, busy0, done0, pass0;
  logic [5:0] i_gates0, err_gate0;
  logic [3:0] fail_vec0;
  logic [1:0] vec_idx0;
  logic [5:0] flip0 [4];

  // Instance 1 (S=1, LOOP=1)
  logic       start1;
  logic       o_a1, o_b1, busy1, done1, pass1;
  logic [5:0] i_gates1, err_gate1;
  logic [3:0] fail_vec1;
  logic [1:0] vec_idx1;

  int n_checks = 0;
  int n_fail   = 0;

  // Gate outputs computed from the number of ones on the inputs.
  function automatic logic [5:0] ideal(input logic a, input logic b);
    int n;
    n = int'(a) + int'(b);
    return {n == 2, n >= 1, n != 2, n == 0, n == 1, n != 1};
  endfunction

  assign i_gates0 = ideal(o_a0, o_b0) ^ flip0[{o_a0, o_b0}];
  assign i_gates1 = ideal(o_a1, o_b1);

  gate_selftest_ctrl #(.SETTLE_CYCLES(S0), .LOOP(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .o_a(o_a0), .o_b(o_b0),
    .i_gates(i_gates0), .busy(busy0), .done(done0), .pass(pass0),
    .fail_vec(fail_vec0), .err_gate(err_gate0), .vec_idx(vec_idx0)
  );

  gate_selftest_ctrl #(.SETTLE_CYCLES(S1), .LOOP(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .o_a(o_a1), .o_b(o_b1),
    .i_gates(i_gates1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_vec(fail_vec1), .err_gate(err_gate1), .vec_idx(vec_idx1)
  );

  // Per-cycle observations of instance 0 (index = cycle after accepting edge)
  logic       tr_busy [64];
  logic       tr_done [64];
  logic [1:0] tr_ab   [64];
  logic [1:0] tr_vi   [64];
  int         done_q  [$];
  logic       r_pass;
  logic [3:0] r_fail;
  logic [5:0] r_err;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_flips();
    for (int k = 0; k < 4; k++) flip0[k] = 6'd0;
  endtask

  // Start one run on instance 0 and record ncyc cycles of outputs.
  // Extra start pulses are asserted during cycles p1/p2; hold keeps start high.
  task automatic do_run(input int ncyc, input int p1, input int p2, input bit hold);
    start0 = 1'b1;
    tick();
    if (!hold) start0 = 1'b0;
    done_q.delete();
    for (int c = 1; c <= ncyc; c++) begin
      tr_busy[c] = busy0;
      tr_done[c] = done0;
      tr_ab[c]   = {o_a0, o_b0};
      tr_vi[c]   = vec_idx0;
      if (done0 === 1'b1) begin
        done_q.push_back(c);
        r_pass = pass0;
        r_fail = fail_vec0;
        r_err  = err_gate0;
      end
      if (!hold) start0 = (c == p1) || (c == p2);
      tick();
    end
    start0 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    clear_flips();
    repeat (2) @(posedge clk);
    #1;
    n_checks += 9;
    if ({o_a0, o_b0} !== 2'b00) begin n_fail++; $display("FAIL reset_ab got %b want 00", {o_a0, o_b0}); end
    if (busy0 !== 1'b0)        begin n_fail++; $display("FAIL reset_busy got %b want 0", busy0); end
    if (done0 !== 1'b0)        begin n_fail++; $display("FAIL reset_done got %b want 0", done0); end
    if (pass0 !== 1'b0)        begin n_fail++; $display("FAIL reset_pass got %b want 0", pass0); end
    if (fail_vec0 !== 4'd0)    begin n_fail++; $display("FAIL reset_fail_vec got %b want 0000", fail_vec0); end
    if (err_gate0 !== 6'd0)    begin n_fail++; $display("FAIL reset_err_gate got %b want 000000", err_gate0); end
    if (vec_idx0 !== 2'd0)     begin n_fail++; $display("FAIL reset_vec_idx got %0d want 0", vec_idx0); end
    if (busy1 !== 1'b0)        begin n_fail++; $display("FAIL reset_busy1 got %b want 0", busy1); end
    if (done1 !== 1'b0)        begin n_fail++; $display("FAIL reset_done1 got %b want 0", done1); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (busy0 !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset busy got %b want 0", busy0); end
  endtask

  task automatic test_ideal();
    int last;
    clear_flips();
    last = 4 * S0 + 5;
    do_run(24, 0, 0, 1'b0);
    for (int c = 1; c <= 24; c++) begin
      logic       eb, ed;
      logic [1:0] eab;
      eb  = (c <= last);
      ed  = (c == last);
      if (c <= 4 * (S0 + 1))  eab = 2'((c - 1) / (S0 + 1));
      else if (c == last)     eab = 2'd3;
      else                    eab = 2'd0;
      n_checks += 4;
      if (tr_busy[c] !== eb)  begin n_fail++; $display("FAIL ideal_busy cycle %0d got %b want %b", c, tr_busy[c], eb); end
      if (tr_done[c] !== ed)  begin n_fail++; $display("FAIL ideal_done cycle %0d got %b want %b", c, tr_done[c], ed); end
      if (tr_ab[c] !== eab)   begin n_fail++; $display("FAIL ideal_ab cycle %0d got %b want %b", c, tr_ab[c], eab); end
      if (tr_vi[c] !== eab)   begin n_fail++; $display("FAIL ideal_vec_idx cycle %0d got %0d want %0d", c, tr_vi[c], eab); end
    end
    n_checks += 5;
    if (done_q.size() != 1) begin n_fail++; $display("FAIL ideal_done_count got %0d want 1", done_q.size()); end
    if (r_pass !== 1'b1)    begin n_fail++; $display("FAIL ideal_pass got %b want 1", r_pass); end
    if (r_fail !== 4'd0)    begin n_fail++; $display("FAIL ideal_fail_vec got %b want 0000", r_fail); end
    if (r_err !== 6'd0)     begin n_fail++; $display("FAIL ideal_err_gate got %b want 000000", r_err); end
    if (pass0 !== 1'b1)     begin n_fail++; $display("FAIL ideal_pass_held got %b want 1", pass0); end
  endtask

  task automatic test_xor_stuck();
    clear_flips();
    // xor stuck at 0 corrupts bit 1 only where the ideal xor is 1
    for (int k = 0; k < 4; k++) begin
      logic [5:0] g;
      g = ideal(k[1], k[0]);
      if (g[1]) flip0[k] = 6'b000010;
    end
    do_run(24, 0, 0, 1'b0);
    n_checks += 5;
    if (done_q.size() != 1)          begin n_fail++; $display("FAIL xor_done_count got %0d want 1", done_q.size()); end
    else if (done_q[0] != 4*S0+5)    begin n_fail++; $display("FAIL xor_done_cycle got %0d want %0d", done_q[0], 4*S0+5); end
    if (r_fail !== 4'b0110)          begin n_fail++; $display("FAIL xor_fail_vec got %b want 0110", r_fail); end
    if (r_err !== 6'b000010)         begin n_fail++; $display("FAIL xor_err_gate got %b want 000010", r_err); end
    if (r_pass !== 1'b0)             begin n_fail++; $display("FAIL xor_pass got %b want 0", r_pass); end
    if (pass0 !== 1'b0)              begin n_fail++; $display("FAIL xor_pass_held got %b want 0", pass0); end
    clear_flips();
  endtask

  task automatic test_extra_starts();
    clear_flips();
    do_run(30, 3, 20, 1'b0);
    n_checks += 4;
    if (done_q.size() != 1)       begin n_fail++; $display("FAIL extra_done_count got %0d want 1", done_q.size()); end
    else if (done_q[0] != 21)     begin n_fail++; $display("FAIL extra_done_cycle got %0d want 21", done_q[0]); end
    if (tr_busy[22] !== 1'b0)     begin n_fail++; $display("FAIL extra_busy_c22 got %b want 0", tr_busy[22]); end
    if (tr_busy[30] !== 1'b0)     begin n_fail++; $display("FAIL extra_busy_c30 got %b want 0", tr_busy[30]); end
    if (r_pass !== 1'b1)          begin n_fail++; $display("FAIL extra_pass got %b want 1", r_pass); end
  endtask

  task automatic test_reset_midrun();
    int seen_done, seen_busy;
    clear_flips();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (9) tick();
    // now in cycle 10
    rst_n = 1'b0;
    #1;
    n_checks += 7;
    if (busy0 !== 1'b0)        begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy0); end
    if ({o_a0, o_b0} !== 2'b0) begin n_fail++; $display("FAIL midrst_ab got %b want 00", {o_a0, o_b0}); end
    if (vec_idx0 !== 2'd0)     begin n_fail++; $display("FAIL midrst_vec_idx got %0d want 0", vec_idx0); end
    if (pass0 !== 1'b0)        begin n_fail++; $display("FAIL midrst_pass got %b want 0", pass0); end
    if (fail_vec0 !== 4'd0)    begin n_fail++; $display("FAIL midrst_fail_vec got %b want 0", fail_vec0); end
    if (err_gate0 !== 6'd0)    begin n_fail++; $display("FAIL midrst_err_gate got %b want 0", err_gate0); end
    if (done0 !== 1'b0)        begin n_fail++; $display("FAIL midrst_done got %b want 0", done0); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    seen_busy = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (done0 !== 1'b0) seen_done++;
      if (busy0 !== 1'b0) seen_busy++;
    end
    n_checks += 2;
    if (seen_done != 0) begin n_fail++; $display("FAIL midrst_no_done got %0d pulses want 0", seen_done); end
    if (seen_busy != 0) begin n_fail++; $display("FAIL midrst_idle got %0d busy cycles want 0", seen_busy); end
  endtask

  task automatic test_fail_then_pass();
    clear_flips();
    flip0[3] = 6'b100000;
    flip0[0] = 6'b000101;
    do_run(24, 0, 0, 1'b0);
    n_checks += 3;
    if (r_fail !== 4'b1001)   begin n_fail++; $display("FAIL ftp_first_fail_vec got %b want 1001", r_fail); end
    if (r_err !== 6'b100101)  begin n_fail++; $display("FAIL ftp_first_err_gate got %b want 100101", r_err); end
    if (r_pass !== 1'b0)      begin n_fail++; $display("FAIL ftp_first_pass got %b want 0", r_pass); end
    clear_flips();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    n_checks += 4;
    if (fail_vec0 !== 4'd0)   begin n_fail++; $display("FAIL ftp_clear_fail_vec got %b want 0000", fail_vec0); end
    if (err_gate0 !== 6'd0)   begin n_fail++; $display("FAIL ftp_clear_err_gate got %b want 000000", err_gate0); end
    if (pass0 !== 1'b0)       begin n_fail++; $display("FAIL ftp_clear_pass got %b want 0", pass0); end
    if (busy0 !== 1'b1)       begin n_fail++; $display("FAIL ftp_busy got %b want 1", busy0); end
    repeat (4 * S0 + 4) tick();
    n_checks += 2;
    if (done0 !== 1'b1)       begin n_fail++; $display("FAIL ftp_second_done got %b want 1", done0); end
    if (pass0 !== 1'b1)       begin n_fail++; $display("FAIL ftp_second_pass got %b want 1", pass0); end
    repeat (3) tick();
  endtask

  task automatic test_random();
    for (int r = 0; r < 20; r++) begin
      logic [3:0] efail;
      logic [5:0] eerr;
      efail = 4'd0;
      eerr  = 6'd0;
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 1) == 1) flip0[k] = 6'($urandom_range(1, 63));
        else                           flip0[k] = 6'd0;
        if (flip0[k] != 6'd0) efail[k] = 1'b1;
        eerr = eerr | flip0[k];
      end
      repeat ($urandom_range(0, 3)) tick();
      do_run(23, 0, 0, 1'b0);
      n_checks += 4;
      if (done_q.size() != 1 || done_q[0] != 4*S0+5) begin
        n_fail++; $display("FAIL rand%0d_done count %0d want 1 at cycle %0d", r, done_q.size(), 4*S0+5);
      end
      if (r_fail !== efail)          begin n_fail++; $display("FAIL rand%0d_fail_vec got %b want %b", r, r_fail, efail); end
      if (r_err !== eerr)            begin n_fail++; $display("FAIL rand%0d_err_gate got %b want %b", r, r_err, eerr); end
      if (r_pass !== (efail == 4'd0)) begin n_fail++; $display("FAIL rand%0d_pass got %b want %b", r, r_pass, efail == 4'd0); end
    end
    clear_flips();
  endtask

  task automatic test_back_to_back();
    clear_flips();
    do_run(45, 0, 0, 1'b1);
    n_checks += 3;
    if (done_q.size() != 2)      begin n_fail++; $display("FAIL b2b_done_count got %0d want 2", done_q.size()); end
    else begin
      if (done_q[0] != 21)       begin n_fail++; $display("FAIL b2b_done0 got %0d want 21", done_q[0]); end
      if (done_q[1] != 43)       begin n_fail++; $display("FAIL b2b_done1 got %0d want 43", done_q[1]); end
    end
    n_checks++;
    if (tr_busy[22] !== 1'b0)    begin n_fail++; $display("FAIL b2b_idle_gap got busy %b want 0", tr_busy[22]); end
    repeat (4 * S0 + 8) tick();
  endtask

  task automatic test_loop();
    int per, ndone, bad_vi, bad_busy, bad_done, bad_res;
    per = 4 * (S1 + 1) + 1;
    ndone = 0; bad_vi = 0; bad_busy = 0; bad_done = 0; bad_res = 0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      int cp;
      logic [1:0] evi;
      cp  = (c - 1) % per;
      evi = (cp < 4 * (S1 + 1)) ? 2'(cp / (S1 + 1)) : 2'd3;
      if (vec_idx1 !== evi || {o_a1, o_b1} !== evi) bad_vi++;
      if (busy1 !== 1'b1) bad_busy++;
      if (done1 !== (c % per == 0)) bad_done++;
      if (done1 === 1'b1) begin
        ndone++;
        if (pass1 !== 1'b1 || fail_vec1 !== 4'd0 || err_gate1 !== 6'd0) bad_res++;
      end
      if (c > per && pass1 !== 1'b1) bad_res++;
      tick();
    end
    n_checks += 5;
    if (ndone != 3)    begin n_fail++; $display("FAIL loop_done_count got %0d want 3", ndone); end
    if (bad_done != 0) begin n_fail++; $display("FAIL loop_done_timing got %0d bad cycles want 0", bad_done); end
    if (bad_vi != 0)   begin n_fail++; $display("FAIL loop_vec_idx got %0d bad cycles want 0", bad_vi); end
    if (bad_busy != 0) begin n_fail++; $display("FAIL loop_busy got %0d bad cycles want 0", bad_busy); end
    if (bad_res != 0)  begin n_fail++; $display("FAIL loop_results got %0d bad cycles want 0", bad_res); end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_xor_stuck();
    test_extra_starts();
    test_fail_then_pass();
    test_reset_midrun();
    test_random();
    test_back_to_back();
    test_loop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
